// File: rtl/ads_sample_avg.sv
// ads_sample_avg: block-averages signed ADS1115 conversion results and presents
// each average on a valid/ready port, with min/max tracking, a hysteresis
// alarm and a sticky overrun flag for results lost to backpressure.
module ads_sample_avg #(
    parameter int unsigned        AVG_LOG2  = 2,
    parameter logic signed [15:0] THRESH_HI = 16'sd16000,
    parameter logic signed [15:0] THRESH_LO = 16'sd15000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [15:0]        sample_data,
    input  logic               clear,
    output logic               avg_valid,
    input  logic               avg_ready,
    output logic [15:0]        avg_data,
    output logic signed [15:0] avg_min,
    output logic signed [15:0] avg_max,
    output logic               alarm,
    output logic               overrun
);

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACC_W      = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W      = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned BLOCK_LAST = (1 << AVG_LOG2) - 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    out_state_e              state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]        count, count_nxt;

    logic signed [DATA_W-1:0] sample_s;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_shift;
    logic signed [DATA_W-1:0] result;
    logic                     block_done;
    logic                     result_load;
    logic                     overrun_set;

    // Sign-extend the incoming sample and form the block sum and its floor average
    always_comb begin
        sample_s   = sample_data;
        sample_ext = ACC_W'(sample_s);
        sum        = acc + sample_ext;
        sum_shift  = sum >>> AVG_LOG2;
        result     = DATA_W'(sum_shift);
        block_done = sample_valid && (count == CNT_W'(BLOCK_LAST));
        result_load = block_done && !clear;
    end

    // Accumulator and sample counter next-state; clear discards any coincident sample
    always_comb begin
        acc_nxt   = acc;
        count_nxt = count;
        if (clear) begin
            acc_nxt   = '0;
            count_nxt = '0;
        end else if (block_done) begin
            acc_nxt   = '0;
            count_nxt = '0;
        end else if (sample_valid) begin
            acc_nxt   = sum;
            count_nxt = count + CNT_W'(1);
        end
    end

    // Output handshake next-state; a new result always leaves the slot FULL
    always_comb begin
        state_nxt   = state;
        overrun_set = 1'b0;
        if (clear) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (result_load) state_nxt = FULL;
                end
                FULL: begin
                    if (result_load) begin
                        state_nxt   = FULL;
                        overrun_set = !avg_ready;
                    end else if (avg_ready) begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // State, accumulator and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
        end
    end

    // Result, statistics, alarm and overrun registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            avg_data <= 16'h0000;
            avg_min  <= 16'sh7FFF;
            avg_max  <= 16'sh8000;
            alarm    <= 1'b0;
            overrun  <= 1'b0;
        end else if (clear) begin
            avg_data <= 16'h0000;
            avg_min  <= 16'sh7FFF;
            avg_max  <= 16'sh8000;
            alarm    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (result_load) begin
                avg_data <= result;
                if (result < avg_min) avg_min <= result;
                if (result > avg_max) avg_max <= result;
                if (result >= THRESH_HI) begin
                    alarm <= 1'b1;
                end else if (result <= THRESH_LO) begin
                    alarm <= 1'b0;
                end
            end
            if (overrun_set) overrun <= 1'b1;
        end
    end

    assign avg_valid = (state == FULL);

endmodule

// File: doc/ads_sample_avg.md
# ads_sample_avg

Downstream consumer of the ADS1115 I2C master. It takes each 16-bit conversion result the master reads from the conversion register, block-averages 2^AVG_LOG2 consecutive samples, and presents each average on a valid/ready output. It also tracks the min/max average since the last clear, raises a hysteresis threshold alarm, and flags results lost to backpressure.

## Interface
- AVG_LOG2, 2: log2 of the averaging window. Legal range is 0..4; 0 means pass-through.
- THRESH_HI, 16'sd16000: signed alarm set level (compare is >=).
- THRESH_LO, 16'sd15000: signed alarm clear level (compare is <=). THRESH_LO <= THRESH_HI is required.
- clk  in  1  system clock (50 MHz, same clock as the I2C master).
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- sample_valid  in  1  one-cycle strobe from the I2C master: conversion result ready.
- sample_data  in  16  conversion result, signed two's complement; sampled when sample_valid=1.
- clear  in  1  synchronous clear of all accumulation, statistics and flags.
- avg_valid  out  1  average available.
- avg_ready  in  1  consumer accepts avg_data when avg_valid && avg_ready.
- avg_data  out  16  signed block average.
- avg_min  out  16  smallest average produced since reset/clear.
- avg_max  out  16  largest average produced since reset/clear.
- alarm  out  1  hysteresis threshold alarm.
- overrun  out  1  sticky: an unconsumed average was overwritten.

## Operation
- Accumulator: signed, 16+AVG_LOG2 bits wide, so no overflow is possible. Sample counter: AVG_LOG2 bits (1 bit when AVG_LOG2=0), wraps modulo 2^AVG_LOG2.
- Accumulation FSM:
  - ACCUM: each sample_valid adds sign-extended sample_data and increments the count.
  - Sample with count == 2^AVG_LOG2-1 (the block-completing sample): sum = acc + sample; result = sum >>> AVG_LOG2 (arithmetic shift, floor toward -inf); acc and count return to 0 on the same edge. No idle gap; the next strobe starts the next block.
- Output FSM:
  - EMPTY -> FULL on a result; avg_valid=1 in FULL.
  - FULL -> EMPTY on avg_valid && avg_ready with no new result that cycle.
  - FULL + new result + avg_ready=0: avg_data is overwritten with the new result, overrun is set, state stays FULL.
  - FULL + new result + avg_ready=1: the old result is consumed, the new one is loaded, state stays FULL, overrun is unchanged.
- Statistics, updated on every produced result, using the new result:
  - avg_min <= min(avg_min, result); avg_max <= max(avg_max, result). Signed compares.
  - alarm: set if result >= THRESH_HI; cleared if result <= THRESH_LO; otherwise held.
- clear:
  - Resets the accumulator, count, output FSM (avg_valid=0), min/max, alarm and overrun.
  - A sample_valid in the same cycle is discarded; clear has priority over everything.
- Reset values: avg_valid=0, avg_data=16'h0000, avg_min=16'h7FFF, avg_max=16'h8000, alarm=0, overrun=0, acc=0, count=0. clear restores the same values.

## Timing
- Latency: the block-completing sample_valid at edge N gives avg_valid=1 and the new avg_data/min/max/alarm visible after edge N, i.e. one cycle after the strobe.
- Handshake:
  - avg_data is stable while avg_valid=1 and no new result arrives.
  - Transfer occurs on a rising edge with avg_valid && avg_ready; avg_valid falls after that edge unless a result loads on the same edge.
  - avg_ready is ignored while avg_valid=0.
- Back-to-back strobes on consecutive cycles must be accepted. The I2C master never issues them, but AVG_LOG2=0 must sustain one result per cycle.
- Reset mid-block asserts asynchronously: outputs take their reset values immediately, and the partial block is lost.
- Sample values at the extremes (0x8000, 0x7FFF) must average exactly, with no wrap.

## Test plan
- Reset: hold reset=0 with sample strobes active -> avg_valid=0, avg_min=0x7FFF, avg_max=0x8000, alarm=0, overrun=0; release reset, no strobes -> all outputs unchanged.
- Basic average (AVG_LOG2=2, avg_ready=1): samples 100, 200, 300, 400 -> avg_valid for exactly one cycle, one cycle after the 4th strobe; avg_data=250, avg_min=avg_max=250.
- Signed/extremes: -1, -1, -1, -2 -> avg_data=0xFFFE (-2). Four samples of 0x8000 -> 0x8000. Four samples of 0x7FFF -> 0x7FFF.
- Backpressure:
  - avg_ready=0, blocks averaging 10 then 20 -> avg_data=20, overrun=1.
  - With overrun=0, assert avg_ready on the cycle the 2nd result loads -> avg_valid stays 1, avg_data=20, overrun=0.
- Alarm hysteresis: block averages 16000 -> alarm=1; then 15500 -> alarm=1; then 15000 -> alarm=0; then 15999 -> alarm=0.
- Clear/reset mid-block:
  - 2 samples of 1000, then clear, then 4 samples of 8 -> avg_data=8.
  - A strobe coincident with clear is dropped.
  - reset pulsed low after 3 samples -> the next 4 samples produce only their own average.
